// File: rtl/nbit_1x4_distributor.sv
// nbit_1x4_distributor
// Registered 1-to-4 distributor. One N-bit word per cycle from a shared source
// is steered into one of four holding registers (A..D) or broadcast to all of
// them. Each destination is a one-entry buffer with a valid/ack handshake, and
// the source sees combinational back-pressure through in_ready.
// A saturating counter tracks the number of accepted transfers.

module nbit_1x4_distributor #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  output logic             in_ready,
  output logic [N-1:0]     out_a,
  output logic [N-1:0]     out_b,
  output logic [N-1:0]     out_c,
  output logic [N-1:0]     out_d,
  output logic             vld_a,
  output logic             vld_b,
  output logic             vld_c,
  output logic             vld_d,
  input  logic             ack_a,
  input  logic             ack_b,
  input  logic             ack_c,
  input  logic             ack_d,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One-hot decode of the destination code, same encoding as the 4-to-1 mux.
  function automatic logic [3:0] sel_decode(input logic [1:0] sel);
    logic [3:0] oh;
    case (sel)
      2'b00:   oh = 4'b0001;
      2'b01:   oh = 4'b0010;
      2'b10:   oh = 4'b0100;
      2'b11:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // Holding registers, indexed 0=A .. 3=D.
  logic [3:0][N-1:0] hold_data_q;
  logic [3:0][N-1:0] hold_data_d;
  logic [3:0]        hold_vld_q;
  logic [3:0]        hold_vld_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [3:0] ack_vec_s;
  logic [3:0] free_s;
  logic [3:0] sel_oh_s;
  logic [3:0] target_s;
  logic [3:0] load_s;
  logic       in_ready_s;
  logic       accept_s;

  // Gather consumer acks and work out which destinations can take a word now.
  always_comb begin
    ack_vec_s = {ack_d, ack_c, ack_b, ack_a};
    // A full slot being acked this cycle frees up in time for a new load.
    free_s    = (~hold_vld_q) | ack_vec_s;
  end

  // Decide the target set and the back-pressure seen by the source.
  always_comb begin
    sel_oh_s = sel_decode(in_sel);
    if (in_bcast) begin
      // Broadcast is all-or-nothing: every destination must be free.
      target_s   = 4'b1111;
      in_ready_s = &free_s;
    end else begin
      target_s   = sel_oh_s;
      in_ready_s = |(free_s & sel_oh_s);
    end
  end

  // Qualify the transfer and produce the per-destination load strobes.
  always_comb begin
    accept_s = in_valid & in_ready_s;
    if (accept_s) begin
      load_s = target_s;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Per-destination EMPTY/FULL update: a load beats a simultaneous ack.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_vld_d  = hold_vld_q;
    for (int i = 0; i < 4; i++) begin
      if (load_s[i]) begin
        hold_data_d[i] = in_data;
        hold_vld_d[i]  = 1'b1;
      end else if (ack_vec_s[i]) begin
        // Data is left in place; consumers ignore it while vld is low.
        hold_vld_d[i]  = 1'b0;
      end else begin
        hold_vld_d[i]  = hold_vld_q[i];
      end
    end
  end

  // Saturating transfer counter; a broadcast counts as a single transfer.
  always_comb begin
    if (accept_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset that drops all held words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hold_data_q[i] <= {N{1'b0}};
      end
      hold_vld_q <= 4'b0000;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready = in_ready_s;
  assign out_a    = hold_data_q[0];
  assign out_b    = hold_data_q[1];
  assign out_c    = hold_data_q[2];
  assign out_d    = hold_data_q[3];
  assign vld_a    = hold_vld_q[0];
  assign vld_b    = hold_vld_q[1];
  assign vld_c    = hold_vld_q[2];
  assign vld_d    = hold_vld_q[3];
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_nbit_1x4_distributor.sv
// Self-checking bench for nbit_1x4_distributor: directed scenarios plus a
// randomized run, all compared against a simple array-based reference model.

module tb_nbit_1x4_distributor;

  localparam int N       = 32;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic [1:0]       in_sel;
  logic             in_bcast;
  logic             in_ready;
  logic [N-1:0]     out_a, out_b, out_c, out_d;
  logic             vld_a, vld_b, vld_c, vld_d;
  logic             ack_a, ack_b, ack_c, ack_d;
  logic [CNT_W-1:0] xfer_cnt;

  nbit_1x4_distributor #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .vld_a(vld_a), .vld_b(vld_b), .vld_c(vld_c), .vld_d(vld_d),
    .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c), .ack_d(ack_d),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Indexable views of the DUT outputs (0=A .. 3=D).
  logic [N-1:0] outs [4];
  logic [3:0]   vld_vec;
  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;
  assign outs[3] = out_d;
  assign vld_vec = {vld_d, vld_c, vld_b, vld_a};

  // Reference model state.
  logic [N-1:0] m_data [4];
  bit   [3:0]   m_vld;
  int           m_cnt;

  int errors = 0;
  int checks = 0;

  function automatic bit m_ready();
    bit [3:0] ackv;
    bit [3:0] free;
    ackv = {ack_d, ack_c, ack_b, ack_a};
    free = ~m_vld | ackv;
    if (in_bcast) return &free;
    return free[in_sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    m_vld = 4'b0000;
    m_cnt = 0;
  endtask

  // Advance the model by one edge with the current inputs, then clock the DUT.
  task automatic tick();
    bit       acc;
    bit [3:0] ackv;
    ackv = {ack_d, ack_c, ack_b, ack_a};
    acc  = in_valid && m_ready();
    for (int i = 0; i < 4; i++) begin
      if (acc && (in_bcast || (int'(in_sel) == i))) begin
        m_data[i] = in_data;
        m_vld[i]  = 1'b1;
      end else if (ackv[i]) begin
        m_vld[i] = 1'b0;
      end
    end
    if (acc && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0; ack_d = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); in_data = '0; in_sel = 2'b00;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs[i] !== 32'h0) begin errors++; $display("FAIL reset_out%0d got=%h exp=0", i, outs[i]); end
    end
    checks++;
    if (vld_vec !== 4'b0000) begin errors++; $display("FAIL reset_vld got=%b exp=0000", vld_vec); end
    checks++;
    if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    // Load B, then pulse reset between edges.
    in_valid = 1'b1; in_sel = 2'b01; in_data = $urandom;
    tick();
    idle();
    checks++;
    if (vld_b !== 1'b1) begin errors++; $display("FAIL pre_rst_vld_b got=%b exp=1", vld_b); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (vld_vec !== 4'b0000) begin errors++; $display("FAIL async_rst_vld got=%b exp=0000", vld_vec); end
    checks++;
    if (out_b !== 32'h0) begin errors++; $display("FAIL async_rst_out_b got=%h exp=0", out_b); end
    checks++;
    if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_cnt got=%0d exp=0", xfer_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_c();
    in_valid = 1'b1; in_sel = 2'b10; in_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (out_c !== 32'hDEADBEEF) begin errors++; $display("FAIL c_first_data got=%h exp=deadbeef", out_c); end
    checks++;
    if (vld_c !== 1'b1) begin errors++; $display("FAIL c_first_vld got=%b exp=1", vld_c); end
    in_data = 32'hCAFEF00D;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL c_full_ready got=%b exp=0", in_ready); end
    tick();
    checks++;
    if (out_c !== 32'hDEADBEEF) begin errors++; $display("FAIL c_stall_data got=%h exp=deadbeef", out_c); end
    checks++;
    if (xfer_cnt !== 8'd1) begin errors++; $display("FAIL c_stall_cnt got=%0d exp=1", xfer_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w;
    int           start_cnt;
    start_cnt = int'(xfer_cnt);
    ack_c = 1'b1; in_valid = 1'b1; in_sel = 2'b10;
    for (int k = 0; k < 5; k++) begin
      w = (k == 0) ? 32'h12345678 : $urandom;
      in_data = w;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, in_ready); end
      tick();
      checks++;
      if (out_c !== w || vld_c !== 1'b1) begin
        errors++; $display("FAIL b2b_c[%0d] got=%h/%b exp=%h/1", k, out_c, vld_c, w);
      end
    end
    checks++;
    if (int'(xfer_cnt) !== start_cnt + 5) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", xfer_cnt, start_cnt + 5); end
    idle();
  endtask

  task automatic test_bcast();
    logic [N-1:0] snap [4];
    int           start_cnt;
    ack_c = 1'b1; tick(); idle();          // drain C
    in_valid = 1'b1; in_sel = 2'b11; in_data = $urandom;
    tick();                                 // fill D
    for (int i = 0; i < 4; i++) snap[i] = outs[i];
    start_cnt = int'(xfer_cnt);
    in_bcast = 1'b1; in_data = 32'hA5A5A5A5; in_sel = $urandom_range(0, 3);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_block_ready got=%b exp=0", in_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs[i] !== snap[i]) begin errors++; $display("FAIL bcast_block_out%0d got=%h exp=%h", i, outs[i], snap[i]); end
    end
    checks++;
    if (vld_vec !== 4'b1000 || int'(xfer_cnt) !== start_cnt) begin
      errors++; $display("FAIL bcast_block_state got=%b/%0d exp=1000/%0d", vld_vec, xfer_cnt, start_cnt);
    end
    ack_d = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bcast_go_ready got=%b exp=1", in_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs[i] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bcast_out%0d got=%h exp=a5a5a5a5", i, outs[i]); end
    end
    checks++;
    if (vld_vec !== 4'b1111) begin errors++; $display("FAIL bcast_vld got=%b exp=1111", vld_vec); end
    checks++;
    if (int'(xfer_cnt) !== start_cnt + 1) begin errors++; $display("FAIL bcast_cnt got=%0d exp=%0d", xfer_cnt, start_cnt + 1); end
    idle();
  endtask

  task automatic test_partial_ack();
    logic [N-1:0] wa, wb, wd, old_c;
    ack_a = 1'b1; ack_b = 1'b1; ack_c = 1'b1; ack_d = 1'b1;
    tick(); idle();                         // drain everything
    wa = $urandom; wb = $urandom; wd = $urandom;
    in_valid = 1'b1;
    in_sel = 2'b00; in_data = wa; tick();
    in_sel = 2'b01; in_data = wb; tick();
    in_sel = 2'b11; in_data = wd; tick();
    idle(); ack_b = 1'b1;
    tick();
    checks++;
    if (vld_a !== 1'b1 || vld_b !== 1'b0 || vld_d !== 1'b1) begin
      errors++; $display("FAIL pack_vld got=%b exp=1001", vld_vec);
    end
    checks++;
    if (out_b !== wb) begin errors++; $display("FAIL pack_out_b got=%h exp=%h", out_b, wb); end
    old_c = out_c;
    ack_b = 1'b1; ack_c = 1'b1;             // acks on empty destinations
    tick();
    checks++;
    if (vld_vec !== 4'b1001 || out_c !== old_c || out_b !== wb) begin
      errors++; $display("FAIL empty_ack got=%b/%h exp=1001/%h", vld_vec, out_c, old_c);
    end
    checks++;
    if (out_a !== wa || out_d !== wd) begin errors++; $display("FAIL empty_ack_ad got=%h/%h exp=%h/%h", out_a, out_d, wa, wd); end
    idle();
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = $urandom_range(0, 3);
      in_bcast = ($urandom_range(0, 7) == 0);
      in_data  = $urandom;
      ack_a = $urandom_range(0, 1); ack_b = $urandom_range(0, 1);
      ack_c = $urandom_range(0, 1); ack_d = $urandom_range(0, 1);
      #1;
      exp_rdy = m_ready();
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy); end
      tick();
      checks++;
      if (vld_vec !== m_vld) begin errors++; $display("FAIL rnd_vld[%0d] got=%b exp=%b", k, vld_vec, m_vld); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outs[i] !== m_data[i]) begin errors++; $display("FAIL rnd_out%0d[%0d] got=%h exp=%h", i, k, outs[i], m_data[i]); end
      end
      checks++;
      if (xfer_cnt !== m_cnt[CNT_W-1:0]) begin errors++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", k, xfer_cnt, m_cnt); end
    end
    idle();
  endtask

  task automatic test_saturation();
    ack_a = 1'b1; ack_b = 1'b1; ack_c = 1'b1; ack_d = 1'b1;
    in_valid = 1'b1; in_bcast = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_sel = $urandom_range(0, 3); in_data = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready[%0d] got=%b exp=1", k, in_ready); end
      tick();
      checks++;
      if (xfer_cnt !== m_cnt[CNT_W-1:0]) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, xfer_cnt, m_cnt); end
    end
    checks++;
    if (xfer_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", xfer_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_c();
    test_back_to_back();
    test_bcast();
    test_partial_ack();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nbit_1x4_distributor.md
Name: nbit_1x4_distributor

Overview:
- Registered 1-to-4 distributor: the opposite direction of the design's N-bit 4-to-1 select mux.
- Accepts one N-bit word per cycle from a shared source bus and steers it into one of four destination holding registers A–D, selected by a 2-bit code with the same encoding as the mux (00=A, 01=B, 10=C, 11=D).
- Supports broadcast to all four destinations and valid/ready back-pressure.
- Used where one shared producer (e.g. the shared memory read bus) feeds several pipeline consumers.

Parameters:
- N, 32, data width of the input bus and of each destination register.
- CNT_W, 8, width of the saturating accepted-transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N  source word.
- in_valid  input  1  source offers in_data this cycle.
- in_sel  input  2  destination select: 00=A, 01=B, 10=C, 11=D.
- in_bcast  input  1  when 1, the word targets all four destinations and in_sel is ignored.
- in_ready  output  1  the distributor accepts the word this cycle.
- out_a, out_b, out_c, out_d  output  N each  destination holding registers.
- vld_a, vld_b, vld_c, vld_d  output  1 each  holding register contains an unconsumed word.
- ack_a, ack_b, ack_c, ack_d  input  1 each  consumer takes the word this cycle; ignored when the matching vld is 0.
- xfer_cnt  output  CNT_W  number of accepted transfers, saturating.

Behaviour:
- Reset (async, rst=1):
  - out_a..out_d = 0.
  - vld_a..vld_d = 0.
  - xfer_cnt = 0.
  - in_ready is combinational and therefore evaluates to 1 while all vld=0.
  - Reset asserted mid-operation discards every held word immediately, with no clock edge needed.
- Per destination x:
  - free_x = !vld_x | ack_x.
  - vld_x=1 and ack_x=0 means full; x holds its value.
- in_ready (combinational, no dependency on in_valid):
  - in_bcast=0: ready = free of the selected destination.
  - in_bcast=1: ready = free_a & free_b & free_c & free_d. There is no partial broadcast.
- Accept: acc = in_valid & in_ready. On a clock edge with acc=1, each targeted destination loads out_x <= in_data and sets vld_x <= 1.
- Clear: on a clock edge where ack_x=1, vld_x=1, and x is not loaded that cycle, vld_x <= 0. out_x keeps its last value; consumers must ignore data when vld=0.
- Simultaneous ack and load on the same x: the load wins. vld_x stays 1 and the new word is visible the next cycle, giving full throughput of one word per cycle per destination.
- Non-targeted destinations: unaffected by acc; only their own ack applies.
- Latency: a word accepted at edge k is on out_x with vld_x=1 immediately after edge k (1-cycle registered).
- in_valid=1 with in_ready=0 (stall): no state change. The source must hold in_data, in_sel and in_bcast stable until accepted.
- Source lowering in_valid while stalled: permitted. Nothing is captured.
- xfer_cnt:
  - Increments by 1 per accepted word; a broadcast counts as 1.
  - Saturates at 2^CNT_W-1 and holds there.
  - Cleared only by rst.
- Pure datapath: no FSM beyond the four per-destination EMPTY/FULL bits (EMPTY→FULL on load; FULL→EMPTY on ack without load; FULL→FULL on load with or without ack).

Test Plan:
- Reset, then rst pulsed mid-stream with vld_b=1 → all vld=0, outs=0, xfer_cnt=0 asynchronously (checked before the next clk edge); in_ready=1.
- Send 0xDEADBEEF with in_sel=10 and no acks → out_c=0xDEADBEEF, vld_c=1 one cycle later. Then a second word to C → in_ready=0, out_c is unchanged, xfer_cnt=1.
- With C full, hold ack_c=1 and send 0x12345678 to C on the same cycle → accepted, out_c=0x12345678, vld_c stays 1. Back-to-back words to C with ack_c held high → one accepted per cycle.
- Broadcast 0xA5A5A5A5 while vld_d=1 and ack_d=0 → in_ready=0 and no destination changes. Assert ack_d → broadcast accepted, all four outs=0xA5A5A5A5, all vld=1, xfer_cnt increments by exactly 1.
- Send words to A, B and D on consecutive cycles, then ack only B → vld_a=1, vld_b=0, vld_d=1, out_b retains its old value. An ack on an empty destination has no effect.
- Run 300 accepted transfers with CNT_W=8 → xfer_cnt holds at 255.
